// File: rtl/val2_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : val2_pkg
//  Description: Shared types for the operand-2 shifter pipeline: shift type,
//               operand mode and the stage-1 control payload.
//  Revision   : 1.0  initial release
// ============================================================================
package val2_pkg;

    // Width of the instruction shifter-operand field
    localparam int c_SO_W  = 12;
    // Width of the shift-amount bus (Rs[7:0])
    localparam int c_AMT_W = 8;

    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROR = 2'b11
    } shift_t;

    typedef enum logic [1:0] {
        MODE_MEM   = 2'd0,
        MODE_IMM   = 2'd1,
        MODE_SHIMM = 2'd2,
        MODE_SHREG = 2'd3
    } mode_t;

    // Decoded control held in stage 1; the data operand travels alongside it
    typedef struct packed {
        mode_t              mode;
        shift_t             sh_type;
        logic [c_AMT_W-1:0] amount;
        logic               c_in;
    } s1_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/val2_shift_core.sv
`default_nettype none
// ============================================================================
//  Module     : val2_shift_core
//  Description: Combinational barrel shifter / rotator producing operand 2
//               and the shifter carry-out. Only DATA_W-wide shifts are used;
//               out-of-range amounts are handled by an explicit mux.
//  Revision   : 1.0  initial release
// ============================================================================
module val2_shift_core
    import val2_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  mode_t               mode,
    input  shift_t              sh_type,
    input  logic [c_AMT_W-1:0]  amount,
    input  logic [DATA_W-1:0]   rm,
    input  logic                c_in,
    output logic [DATA_W-1:0]   val2,
    output logic                carry
);

    localparam int              AMT_W = $clog2(DATA_W);
    localparam logic [c_AMT_W:0] c_W_CMP = (c_AMT_W + 1)'(DATA_W);

    logic [AMT_W-1:0]  w_s;
    logic [AMT_W-1:0]  w_s_neg;
    logic [AMT_W-1:0]  w_s_m1;
    logic [DATA_W-1:0] w_rot;
    logic [DATA_W-1:0] w_lsl;
    logic [DATA_W-1:0] w_lsr;
    logic [DATA_W-1:0] w_asr;
    logic              w_zero;
    logic              w_lt_w;
    logic              w_eq_w;

    // w_s_neg is (W - n) mod W: the bit that leaves last on a left shift,
    // and the complementary amount for the rotate.
    assign w_s     = amount[AMT_W-1:0];
    assign w_s_neg = -w_s;
    assign w_s_m1  = w_s - AMT_W'(1);
    assign w_rot   = (rm >> w_s) | (rm << w_s_neg);
    assign w_lsl   = rm << w_s;
    assign w_lsr   = rm >> w_s;
    assign w_asr   = $unsigned($signed(rm) >>> w_s);
    assign w_zero  = (amount == '0);
    assign w_lt_w  = ({1'b0, amount} <  c_W_CMP);
    assign w_eq_w  = ({1'b0, amount} == c_W_CMP);

    // Select result and carry by mode, shift type and amount range
    always_comb begin
        val2  = rm;
        carry = c_in;
        case (mode)
            MODE_MEM: begin
                val2  = rm;
                carry = c_in;
            end
            MODE_IMM: begin
                // Rotation of zero leaves C untouched
                val2  = w_rot;
                carry = w_zero ? c_in : w_rot[DATA_W-1];
            end
            default: begin
                if ((mode == MODE_SHIMM) && (sh_type == ROR) && w_zero) begin
                    // ROR #0 in the immediate form encodes RRX
                    val2  = {c_in, rm[DATA_W-1:1]};
                    carry = rm[0];
                end else if (!w_zero) begin
                    case (sh_type)
                        LSL: begin
                            if (w_lt_w) begin
                                val2  = w_lsl;
                                carry = rm[w_s_neg];
                            end else begin
                                val2  = '0;
                                carry = w_eq_w ? rm[0] : 1'b0;
                            end
                        end
                        LSR: begin
                            if (w_lt_w) begin
                                val2  = w_lsr;
                                carry = rm[w_s_m1];
                            end else begin
                                val2  = '0;
                                carry = w_eq_w ? rm[DATA_W-1] : 1'b0;
                            end
                        end
                        ASR: begin
                            if (w_lt_w) begin
                                val2  = w_asr;
                                carry = rm[w_s_m1];
                            end else begin
                                val2  = {DATA_W{rm[DATA_W-1]}};
                                carry = rm[DATA_W-1];
                            end
                        end
                        default: begin
                            // Rotation by a multiple of W is the identity
                            if (w_s == '0) begin
                                val2  = rm;
                                carry = rm[DATA_W-1];
                            end else begin
                                val2  = w_rot;
                                carry = w_rot[DATA_W-1];
                            end
                        end
                    endcase
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/val2_shifter_pipe.sv
`default_nettype none
// ============================================================================
//  Module     : val2_shifter_pipe
//  Description: Two-stage operand-2 unit for the EXE stage. Stage 1 decodes
//               the operand mode and shift amount, stage 2 registers the
//               shifter result and carry. Valid/ready on both sides, flush.
//  Revision   : 1.0  initial release
// ============================================================================
module val2_shifter_pipe
    import val2_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 8,
    parameter int OFF_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [DATA_W-1:0] val_rs,
    input  logic [c_SO_W-1:0] shift_operand,
    input  logic              imm,
    input  logic              val2_src,
    input  logic              c_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] val2,
    output logic              carry_out
);

    s1_ctrl_t          w_ctrl;
    logic [DATA_W-1:0] w_operand;
    logic              w_s1_moves;
    logic              w_s1_open;
    logic              w_accept;
    logic [DATA_W-1:0] w_core_val2;
    logic              w_core_carry;
    logic              w_unused_rs;

    s1_ctrl_t          r_s1_ctrl;
    logic [DATA_W-1:0] r_s1_rm;
    logic              r_s1_valid;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_val2;
    logic              r_carry;

    // Only the low byte of Rs carries a shift amount
    assign w_unused_rs = ^val_rs[DATA_W-1:c_AMT_W];

    // Handshake: stage 1 advances whenever stage 2 is empty or draining.
    // A flush cycle also refuses new work so upstream never sees a
    // handshake that the pipe then discards.
    assign w_s1_moves = !r_s2_valid || out_ready;
    assign w_s1_open  = !r_s1_valid || w_s1_moves;
    assign in_ready   = !rst && !flush && w_s1_open;
    assign w_accept   = in_valid && in_ready;

    // Decode mode (val2_src > imm > register) and pre-shape the operand
    always_comb begin
        w_ctrl.mode    = MODE_SHIMM;
        w_ctrl.sh_type = shift_t'(shift_operand[6:5]);
        w_ctrl.amount  = '0;
        w_ctrl.c_in    = c_in;
        w_operand      = val_rm;
        if (val2_src) begin
            w_ctrl.mode = MODE_MEM;
            w_operand   = DATA_W'(shift_operand[OFF_W-1:0]);
        end else if (imm) begin
            w_ctrl.mode   = MODE_IMM;
            w_ctrl.amount = {3'b000, shift_operand[11:8], 1'b0};
            w_operand     = DATA_W'(shift_operand[IMM_W-1:0]);
        end else if (shift_operand[4]) begin
            w_ctrl.mode   = MODE_SHREG;
            w_ctrl.amount = val_rs[c_AMT_W-1:0];
        end else begin
            w_ctrl.mode   = MODE_SHIMM;
            w_ctrl.amount = {3'b000, shift_operand[11:7]};
            // LSR #0 and ASR #0 encode a shift by 32
            if ((shift_operand[11:7] == 5'd0) &&
                ((w_ctrl.sh_type == LSR) || (w_ctrl.sh_type == ASR))) begin
                w_ctrl.amount = 8'd32;
            end
        end
    end

    // Stage 1 register: decoded control plus operand
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_ctrl  <= '0;
            r_s1_rm    <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else begin
            if (w_s1_open) begin
                r_s1_valid <= w_accept;
            end
            if (w_accept) begin
                r_s1_ctrl <= w_ctrl;
                r_s1_rm   <= w_operand;
            end
        end
    end

    val2_shift_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .mode    (r_s1_ctrl.mode),
        .sh_type (r_s1_ctrl.sh_type),
        .amount  (r_s1_ctrl.amount),
        .rm      (r_s1_rm),
        .c_in    (r_s1_ctrl.c_in),
        .val2    (w_core_val2),
        .carry   (w_core_carry)
    );

    // Stage 2 register: result held stable while the ALU stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_val2     <= '0;
            r_carry    <= 1'b0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s1_moves) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_val2  <= w_core_val2;
                r_carry <= w_core_carry;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign val2      = r_val2;
    assign carry_out = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_val2_shifter_pipe.sv
`default_nettype none
// ============================================================================
//  Module     : tb_val2_shifter_pipe
//  Description: Self-checking bench for val2_shifter_pipe. A queue-based
//               reference model predicts handshakes and results computed
//               with wide arithmetic straight from the ARM shifter rules.
//  Revision   : 1.0  initial release
// ============================================================================
module tb_val2_shifter_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, imm, val2_src, c_in;
    logic        out_valid, out_ready, carry_out;
    logic [31:0] val_rm, val_rs, val2;
    logic [11:0] shift_operand;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          edge_cnt = 0;
    logic [32:0] exp_q[$];
    int          stamp_q[$];

    always #5 clk = ~clk;

    val2_shifter_pipe #(
        .DATA_W (32),
        .IMM_W  (8),
        .OFF_W  (12)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .val_rm        (val_rm),
        .val_rs        (val_rs),
        .shift_operand (shift_operand),
        .imm           (imm),
        .val2_src      (val2_src),
        .c_in          (c_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .val2          (val2),
        .carry_out     (carry_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference result {carry, val2} from the architectural shifter rules
    function automatic logic [32:0] ref_model(input logic [31:0] rm, input logic [31:0] rs,
                                              input logic [11:0] so, input logic i,
                                              input logic src, input logic cin);
        logic [63:0] e;
        int          n;
        int          t;
        if (src) return {cin, 20'd0, so};
        if (i) begin
            n = 2 * int'(so[11:8]);
            e = {24'd0, so[7:0], 24'd0, so[7:0]} >> n;
            return {(n == 0) ? cin : e[31], e[31:0]};
        end
        t = int'(so[6:5]);
        if (so[4]) begin
            n = int'(rs[7:0]);
        end else begin
            n = int'(so[11:7]);
            if (n == 0) begin
                if (t == 0) return {cin, rm};
                if (t == 3) return {rm[0], cin, rm[31:1]};
                n = 32;
            end
        end
        if (n == 0) return {cin, rm};
        case (t)
            0: begin
                e = {32'd0, rm} << n;
                return {(n <= 32) ? e[32] : 1'b0, e[31:0]};
            end
            1: begin
                e = {rm, 32'd0} >> n;
                return {(n <= 32) ? e[31] : 1'b0, e[63:32]};
            end
            2: begin
                if (n >= 32) return {rm[31], {32{rm[31]}}};
                e = $signed({rm, 32'd0}) >>> n;
                return {e[31], e[63:32]};
            end
            default: begin
                n = n % 32;
                if (n == 0) return {rm[31], rm};
                e = {rm, rm} >> n;
                return {e[31], e[31:0]};
            end
        endcase
    endfunction

    // One clock: check outputs mid-cycle, update the model, advance an edge
    task automatic tick(output bit acc);
        bit exp_ready;
        bit exp_ov;
        @(negedge clk);
        exp_ready = !rst && !flush && ((exp_q.size() < 2) || out_ready);
        exp_ov    = (exp_q.size() > 0) && (edge_cnt > stamp_q[0]);
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov && out_valid) begin
            check("val2", 64'(val2), 64'(exp_q[0][31:0]));
            check("carry_out", 64'(carry_out), 64'(exp_q[0][32]));
        end
        acc = in_valid && exp_ready;
        if (rst || flush) begin
            exp_q.delete();
            stamp_q.delete();
        end else begin
            if (exp_ov && out_ready) begin
                void'(exp_q.pop_front());
                void'(stamp_q.pop_front());
            end
            if (acc) begin
                exp_q.push_back(ref_model(val_rm, val_rs, shift_operand, imm, val2_src, c_in));
                stamp_q.push_back(edge_cnt + 1);
            end
        end
        @(posedge clk);
        edge_cnt++;
        #1;
    endtask

    task automatic rand_req();
        val_rm = $urandom;
        val_rs = $urandom;
        if ($urandom_range(0, 1) == 1) val_rs[7:0] = 8'($urandom_range(0, 40));
        shift_operand = 12'($urandom);
        imm      = ($urandom_range(0, 3) == 0);
        val2_src = ($urandom_range(0, 7) == 0);
        c_in     = 1'($urandom);
    endtask

    // Single request with known architectural answer
    task automatic single(input string tag, input logic [31:0] rm, input logic [31:0] rs,
                          input logic [11:0] so, input logic i, input logic src,
                          input logic cin, input logic [31:0] ev, input logic ec);
        bit a;
        int waited;
        val_rm = rm; val_rs = rs; shift_operand = so;
        imm = i; val2_src = src; c_in = cin;
        in_valid = 1'b1; out_ready = 1'b1;
        tick(a);
        in_valid = 1'b0;
        check({tag, "_accept"}, 64'(a), 64'd1);
        waited = 0;
        while (!out_valid && waited < 8) begin
            tick(a);
            waited++;
        end
        check({tag, "_latency"}, 64'(waited), 64'd1);
        check({tag, "_val2"}, 64'(val2), 64'(ev));
        check({tag, "_carry"}, 64'(carry_out), 64'(ec));
        tick(a);
    endtask

    initial begin : main
        bit a;
        int sent;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        imm = 1'b0; val2_src = 1'b0; c_in = 1'b0;
        val_rm = '0; val_rs = '0; shift_operand = '0;
        @(posedge clk);
        #1;
        tick(a);
        tick(a);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_val2", 64'(val2), 64'd0);
        check("reset_carry", 64'(carry_out), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        tick(a);

        // Directed vectors
        single("imm_rot",  32'h0,        32'h0,  12'h4FF, 1'b1, 1'b0, 1'b0, 32'hFF000000, 1'b1);
        single("lsr_rs32", 32'h80000001, 32'd32, 12'h030, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1);
        single("lsr_rs33", 32'h80000001, 32'd33, 12'h030, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0);
        single("rrx",      32'h00000003, 32'h0,  12'h060, 1'b0, 1'b0, 1'b1, 32'h80000001, 1'b1);
        single("mem_off",  32'hDEADBEEF, 32'h0,  12'hABC, 1'b1, 1'b1, 1'b1, 32'h00000ABC, 1'b1);
        single("lsl_rs0",  32'h12345678, 32'h100, 12'h010, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0);

        // Back-to-back with output stall: two queue, then in_ready drops
        sent = 0;
        rand_req();
        for (int c = 0; c < 24 && (sent < 4 || exp_q.size() > 0); c++) begin
            out_ready = (c >= 5);
            in_valid  = (sent < 4);
            tick(a);
            if (a) begin
                sent++;
                rand_req();
            end
            if (c >= 2 && c <= 4) check("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        check("bp_all_sent", 64'(sent), 64'd4);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Flush with two in flight and a request pending
        out_ready = 1'b0; in_valid = 1'b1;
        rand_req(); tick(a);
        rand_req(); tick(a);
        flush = 1'b1; rand_req();
        check("flush_in_ready", 64'(in_ready), 64'd0);
        tick(a);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush_ov_0", 64'(out_valid), 64'd0);
        tick(a);
        check("flush_ov_1", 64'(out_valid), 64'd0);
        tick(a);
        check("flush_ov_2", 64'(out_valid), 64'd0);

        // Reset pulse mid-stream clears valid and data
        out_ready = 1'b0; in_valid = 1'b1;
        val_rm = '0; val_rs = '0; shift_operand = 12'h4FF;
        imm = 1'b1; val2_src = 1'b0; c_in = 1'b0;
        tick(a);
        rand_req(); tick(a);
        check("rst_pre_val2", 64'(val2), 64'hFF000000);
        rst = 1'b1; in_valid = 1'b1;
        tick(a);
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_val2", 64'(val2), 64'd0);
        check("rst_mid_carry", 64'(carry_out), 64'd0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(a);

        // Randomized traffic against the model
        for (int k = 0; k < 10000; k++) begin
            if (a || !in_valid) rand_req();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            tick(a);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) tick(a);
        check("final_drain", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
